// File: rtl/dm_abstract_ctl_pkg.sv
// Shared definitions for the debug-module abstract-command controller:
// DMI register map, register field positions, cmderr codes, FSM states.
package dm_pkg;

  localparam logic [6:0] DMI_ADDR_DATA0      = 7'h04;
  localparam logic [6:0] DMI_ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] DMI_ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] DMI_ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DMI_ADDR_COMMAND    = 7'h17;

  localparam int unsigned DMC_DMACTIVE  = 0;
  localparam int unsigned DMC_RESUMEREQ = 30;
  localparam int unsigned DMC_HALTREQ   = 31;

  localparam int unsigned DMS_VERSION_LSB   = 0;
  localparam int unsigned DMS_AUTHENTICATED = 7;
  localparam int unsigned DMS_ANYHALTED     = 8;
  localparam int unsigned DMS_ALLHALTED     = 9;
  localparam int unsigned DMS_ANYRESUMEACK  = 16;
  localparam int unsigned DMS_ALLRESUMEACK  = 17;
  localparam logic [3:0]  DMS_VERSION       = 4'd2;

  localparam int unsigned ACS_DATACOUNT_LSB   = 0;
  localparam int unsigned ACS_CMDERR_LSB      = 8;
  localparam int unsigned ACS_BUSY            = 12;
  localparam int unsigned ACS_PROGBUFSIZE_LSB = 24;
  localparam logic [3:0]  ACS_DATACOUNT       = 4'd1;
  localparam logic [4:0]  ACS_PROGBUFSIZE     = 5'd0;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
  localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } abs_state_e;

  function automatic logic cmdtype_supported(input logic [7:0] cmdtype);
    return (cmdtype == CMDTYPE_ACCESS_REG) || (cmdtype == CMDTYPE_ACCESS_MEM);
  endfunction

endpackage

// File: rtl/dm_abstract_ctl_if.sv
// DMI access bus between the debug transport (master) and the debug module (slave).
interface dm_abstract_ctl_if #(
  parameter int DMI_AW = 7,
  parameter int XLEN   = 32
) ();
  logic              dmi_req;
  logic              dmi_wr;
  logic [DMI_AW-1:0] dmi_addr;
  logic [XLEN-1:0]   dmi_wdata;
  logic [XLEN-1:0]   dmi_rdata;
  logic              dmi_ack;

  modport master (
    output dmi_req, dmi_wr, dmi_addr, dmi_wdata,
    input  dmi_rdata, dmi_ack
  );

  modport slave (
    input  dmi_req, dmi_wr, dmi_addr, dmi_wdata,
    output dmi_rdata, dmi_ack
  );
endinterface

// File: rtl/dm_abstract_ctl_cmderr.sv
// cmderr register: the first error raised is sticky until cleared by W1C;
// core-side errors take priority over DMI-side errors in the same cycle.
module dm_cmderr_unit
  import dm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       core_err_v,
  input  logic [2:0] core_err,
  input  logic       dmi_err_v,
  input  logic [2:0] dmi_err,
  input  logic       w1c_en,
  input  logic [2:0] w1c_mask,
  output logic [2:0] cmderr
);

  // Sticky error capture; W1C only acts on an already-latched error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmderr <= '0;
    end else if (clr) begin
      cmderr <= '0;
    end else if (cmderr == CMDERR_NONE) begin
      if (core_err_v)
        cmderr <= core_err;
      else if (dmi_err_v)
        cmderr <= dmi_err;
    end else if (w1c_en) begin
      cmderr <= cmderr & ~w1c_mask;
    end
  end

endmodule

// File: rtl/dm_abstract_ctl.sv
// Debug-module-side controller: decodes DMI register accesses, drives the
// core halt/resume requests and the abstract-command execution handshake.
module dm_abstract_ctl
  import dm_pkg::*;
#(
  parameter int DMI_AW = 7,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dm_abstract_ctl_if.slave dmi,
  output logic            halt_req,
  output logic            resume_req,
  output logic            exec,
  output logic [XLEN-1:0] command,
  output logic [XLEN-1:0] data0_out,
  input  logic            halted,
  input  logic            done,
  input  logic            write,
  input  logic [XLEN-1:0] data_in,
  input  logic            error
);

  abs_state_e      state;
  logic            dmactive;
  logic            resumeack;
  logic [2:0]      cmderr;
  logic            busy;
  logic            wr_req, rd_req;
  logic            hit_data0, hit_dmc, hit_dms, hit_acs, hit_cmd;
  logic            deact;
  logic            core_done, core_abort, cmd_start;
  logic            core_err_v, dmi_err_v;
  logic [2:0]      core_err, dmi_err;
  logic [7:0]      cmdtype;
  logic [XLEN-1:0] rd_val;

  assign busy       = (state == ST_EXEC);
  assign wr_req     = dmi.dmi_req & dmi.dmi_wr;
  assign rd_req     = dmi.dmi_req & ~dmi.dmi_wr;
  assign hit_data0  = (dmi.dmi_addr == DMI_AW'(DMI_ADDR_DATA0));
  assign hit_dmc    = (dmi.dmi_addr == DMI_AW'(DMI_ADDR_DMCONTROL));
  assign hit_dms    = (dmi.dmi_addr == DMI_AW'(DMI_ADDR_DMSTATUS));
  assign hit_acs    = (dmi.dmi_addr == DMI_AW'(DMI_ADDR_ABSTRACTCS));
  assign hit_cmd    = (dmi.dmi_addr == DMI_AW'(DMI_ADDR_COMMAND));
  assign deact      = wr_req & hit_dmc & ~dmi.dmi_wdata[DMC_DMACTIVE];
  assign core_done  = busy & done;
  assign core_abort = busy & ~done & ~halted;
  assign cmdtype    = dmi.dmi_wdata[31:24];

  // Error sources and command-accept decision for this cycle's access.
  always_comb begin
    core_err_v = 1'b0;
    core_err   = CMDERR_NONE;
    dmi_err_v  = 1'b0;
    dmi_err    = CMDERR_NONE;
    cmd_start  = 1'b0;
    if (core_done && error) begin
      core_err_v = 1'b1;
      core_err   = CMDERR_EXCEPTION;
    end else if (core_abort) begin
      core_err_v = 1'b1;
      core_err   = CMDERR_HALTRESUME;
    end
    if (wr_req && hit_cmd && (cmderr == CMDERR_NONE)) begin
      dmi_err_v = 1'b1;
      if (busy)
        dmi_err = CMDERR_BUSY;
      else if (!cmdtype_supported(cmdtype))
        dmi_err = CMDERR_NOTSUP;
      else if (!halted)
        dmi_err = CMDERR_HALTRESUME;
      else begin
        dmi_err_v = 1'b0;
        cmd_start = 1'b1;
      end
    end
    if (dmi.dmi_req && hit_data0 && busy) begin
      dmi_err_v = 1'b1;
      dmi_err   = CMDERR_BUSY;
    end
  end

  // Read data for the register addressed this cycle.
  always_comb begin
    rd_val = '0;
    if (hit_data0) begin
      rd_val = data0_out;
    end else if (hit_dmc) begin
      rd_val[DMC_HALTREQ]  = halt_req;
      rd_val[DMC_DMACTIVE] = dmactive;
    end else if (hit_dms) begin
      rd_val[DMS_ALLRESUMEACK]         = resumeack;
      rd_val[DMS_ANYRESUMEACK]         = resumeack;
      rd_val[DMS_ALLHALTED]            = halted;
      rd_val[DMS_ANYHALTED]            = halted;
      rd_val[DMS_AUTHENTICATED]        = 1'b1;
      rd_val[DMS_VERSION_LSB +: 4]     = DMS_VERSION;
    end else if (hit_acs) begin
      rd_val[ACS_PROGBUFSIZE_LSB +: 5] = ACS_PROGBUFSIZE;
      rd_val[ACS_BUSY]                 = busy;
      rd_val[ACS_CMDERR_LSB +: 3]      = cmderr;
      rd_val[ACS_DATACOUNT_LSB +: 4]   = ACS_DATACOUNT;
    end
  end

  dm_cmderr_unit u_cmderr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (deact),
    .core_err_v (core_err_v),
    .core_err   (core_err),
    .dmi_err_v  (dmi_err_v),
    .dmi_err    (dmi_err),
    .w1c_en     (wr_req & hit_acs),
    .w1c_mask   (dmi.dmi_wdata[ACS_CMDERR_LSB +: 3]),
    .cmderr     (cmderr)
  );

  // DMI response, run-control latches and abstract-command FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi.dmi_ack   <= 1'b0;
      dmi.dmi_rdata <= '0;
      state         <= ST_IDLE;
      dmactive      <= 1'b0;
      halt_req      <= 1'b0;
      resume_req    <= 1'b0;
      resumeack     <= 1'b0;
      exec          <= 1'b0;
      command       <= '0;
      data0_out     <= '0;
    end else begin
      dmi.dmi_ack   <= dmi.dmi_req;
      dmi.dmi_rdata <= rd_req ? rd_val : '0;
      if (deact) begin
        // dmactive=0 behaves as a synchronous reset of everything else;
        // a done arriving afterwards finds the FSM idle and is dropped.
        state      <= ST_IDLE;
        dmactive   <= 1'b0;
        halt_req   <= 1'b0;
        resume_req <= 1'b0;
        resumeack  <= 1'b0;
        exec       <= 1'b0;
        command    <= '0;
        data0_out  <= '0;
      end else begin
        if (resume_req && !halted) begin
          resume_req <= 1'b0;
          resumeack  <= 1'b1;
        end
        if (wr_req && hit_dmc) begin
          dmactive <= 1'b1;
          halt_req <= dmi.dmi_wdata[DMC_HALTREQ];
          if (dmi.dmi_wdata[DMC_RESUMEREQ] && !dmi.dmi_wdata[DMC_HALTREQ] && halted) begin
            resume_req <= 1'b1;
            resumeack  <= 1'b0;
          end
        end
        if (core_done && write)
          data0_out <= data_in;
        else if (wr_req && hit_data0 && !busy)
          data0_out <= dmi.dmi_wdata;
        case (state)
          ST_IDLE: begin
            if (cmd_start) begin
              command <= dmi.dmi_wdata;
              state   <= ST_EXEC;
              exec    <= 1'b1;
            end
          end
          ST_EXEC: begin
            if (done || !halted) begin
              state <= ST_IDLE;
              exec  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            exec  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
